uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Parametrised UART receiver: oversampled start detection, 5-9 data bits, optional parity, 1 or 2 stop bits.
- Per-character error flags and an overrun indication.
- Sits between the board RXD pin and the UART RX FIFO; delivers characters on a valid/ready interface.
- Generalises the fixed 8N1, 115200 receive path so one core serves every UART instance.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; even, 8..32.
- DATA_BITS, 8, character width; 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- SYNC_STAGES, 2, RXD synchroniser depth; 2..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uart_rxd  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received character, LSB = first bit on the line
- rx_valid  out  1  rx_data and the error flags are valid
- rx_ready  in  1  consumer accepts the character
- rx_frame_err  out  1  a stop bit sampled 0; qualified by rx_valid
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid; always 0 when PARITY=0
- rx_overrun  out  1  one-cycle pulse when a completed character is dropped
- rx_break  out  1  break flag; qualified by rx_valid; see Optional Feature

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: rx_data=0, rx_valid=0, all flags 0, synchroniser flops=1, FSM=IDLE, tick counter=0.
  - Reset asserted mid-character aborts the character with no output and no flags.
- Tick generation:
  - DIV = round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)); default is 54.
  - Tick counter runs 0..DIV-1; a tick is issued on DIV-1.
  - The counter is cleared on start-edge detection so sampling phase aligns to the edge.
  - A sample counter counts ticks within each bit.
- Synchroniser: SYNC_STAGES flops plus one history flop. The FSM sees only the synchronised line.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised 1->0 edge (history=1, current=0). A line held low never re-triggers.
  - START: sample at tick OVERSAMPLE/2-1.
    - Sample 1: glitch; go to IDLE, no output.
    - Sample 0: reset the sample counter; go to DATA.
  - DATA: sample every OVERSAMPLE ticks (mid-bit). Shift in LSB first. After DATA_BITS samples go to PARITY if PARITY!=0, else STOP.
  - PARITY: one mid-bit sample. Error = XOR(data, parity bit) != 0 for even, == 0 for odd.
  - STOP: sample STOP_BITS bits. frame_err is set if any stop sample is 0.
    - After the final stop sample the character completes and the FSM goes to IDLE immediately, without waiting for the end of the stop bit. This tolerates a sender up to half a bit fast.
- Output register:
  - On completion, rx_data and flags load and rx_valid=1 on the next clk.
  - rx_valid, rx_data and the flags stay stable until a cycle with rx_valid & rx_ready, then rx_valid drops the following clk.
- Simultaneous handshake and completion: the handshake succeeds, the new character loads, and rx_valid stays 1 with no gap.
- Completion with rx_valid=1 and rx_ready=0: the new character is discarded, held data is unchanged, and rx_overrun pulses for exactly one clk.
- Latency: start edge on the pin to rx_valid = SYNC_STAGES+1 clks plus (1+DATA_BITS+P+STOP_BITS-0.5) bit times, ±1 tick, where P=1 if parity is enabled. For 8N1 this is 9.5 bit times.
- Elaboration: illegal parameter values stop elaboration with $fatal.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN
- Defined:
  - A character with all data bits 0, parity bit 0 and the first stop bit 0 is reported with rx_break=1 and rx_frame_err=1.
  - The FSM then waits in an added BREAK state until the synchronised line is 1 for a full bit time before returning to IDLE.
  - rx_overrun rules still apply.
- Undefined: rx_break is tied 0 and there is no BREAK state. A frame error returns directly to IDLE, and the edge detector prevents false restarts.

Test Plan:
- Defaults, send 0xA5 8N1 with rx_ready=1 -> one rx_valid pulse with rx_data=0xA5 and all flags 0; rx_valid rises 9.5 bit times (±1 tick) after the start edge.
- 0.3-bit low glitch on idle line -> no rx_valid, FSM back in IDLE, next 0x3C received correctly.
- PARITY=1, DATA_BITS=7: send 0x41 with correct parity, then 0x41 with the parity bit flipped -> rx_data=0x41 both times; rx_parity_err 0 then 1.
- Send 0x55 with stop bit forced 0, then 0xFF normally -> first character 0x55 with frame_err=1, second 0xFF clean.
- rx_ready=0: send 0x11 then 0x22 -> rx_data holds 0x11 and rx_overrun pulses 1 clk; raise rx_ready -> 0x11 consumed and rx_valid drops; 0x22 is never presented.
- UART_RX_BREAK_DET_EN defined: line low for 20 bit times, then high -> single character 0x00 with rx_break=1 and frame_err=1; next character 0x7E received cleanly.

Source files
------------

// File: rtl/uart_rx_core.sv
// Parametrised oversampling UART receiver with valid/ready character output.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_core #(
   parameter int unsigned CLK_FREQ    = 100000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   output logic                 rx_break
);

   localparam int unsigned DIV    = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = 4;
   localparam int unsigned HALF   = OVERSAMPLE / 2 - 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
   localparam logic [2:0] S_BREAK  = 3'd5;
`endif

   generate
      if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
         $fatal(1, "uart_rx_core: OVERSAMPLE must be even and in 8..32");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
         $fatal(1, "uart_rx_core: DATA_BITS must be in 5..9");
      end
      if (PARITY > 2) begin : g_bad_par
         $fatal(1, "uart_rx_core: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $fatal(1, "uart_rx_core: STOP_BITS must be 1 or 2");
      end
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $fatal(1, "uart_rx_core: SYNC_STAGES must be in 2..4");
      end
      if (DIV < 1) begin : g_bad_div
         $fatal(1, "uart_rx_core: clock too slow for BAUD_RATE*OVERSAMPLE");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rxd_s;
   logic                   edge_c;
   logic [TICK_W-1:0]      tick_cnt_q;
   logic                   tick_c;

   logic [2:0]             state_q, state_nxt;
   logic [SAMP_W-1:0]      samp_q, samp_nxt;
   logic [BIT_W-1:0]       bit_q, bit_nxt;
   logic [DATA_BITS-1:0]   shift_q, shift_nxt;
   logic                   par_err_q, par_err_nxt;
   logic                   frame_q, frame_nxt;
   logic                   done_c;
`ifdef UART_RX_BREAK_DET_EN
   logic                   par_bit_q, par_bit_nxt;
   logic                   brk_q, brk_nxt;
`endif

   assign rxd_s  = sync_q[SYNC_STAGES-1];
   assign edge_c = hist_q & ~rxd_s;
   assign tick_c = (tick_cnt_q == TICK_W'(DIV - 1));

   // Metastability synchroniser plus history flop for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
         hist_q <= rxd_s;
      end
   end

   // Oversample tick divider, re-phased on the start edge
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else if ((state_q == S_IDLE && edge_c) || tick_c) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         samp_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         frame_q   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         par_bit_q <= 1'b0;
         brk_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_nxt;
         samp_q    <= samp_nxt;
         bit_q     <= bit_nxt;
         shift_q   <= shift_nxt;
         par_err_q <= par_err_nxt;
         frame_q   <= frame_nxt;
`ifdef UART_RX_BREAK_DET_EN
         par_bit_q <= par_bit_nxt;
         brk_q     <= brk_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state_q;
      samp_nxt    = samp_q;
      bit_nxt     = bit_q;
      shift_nxt   = shift_q;
      par_err_nxt = par_err_q;
      frame_nxt   = frame_q;
      done_c      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_nxt = par_bit_q;
      brk_nxt     = brk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (edge_c) begin
               state_nxt   = S_START;
               samp_nxt    = '0;
               bit_nxt     = '0;
               par_err_nxt = 1'b0;
               frame_nxt   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
               par_bit_nxt = 1'b0;
               brk_nxt     = 1'b0;
`endif
            end
         end
         S_START: begin
            if (tick_c) begin
               if (samp_q == SAMP_W'(HALF)) begin
                  samp_nxt  = '0;
                  state_nxt = rxd_s ? S_IDLE : S_DATA;
               end else begin
                  samp_nxt = samp_q + SAMP_W'(1);
               end
            end
         end
         S_DATA: begin
            if (tick_c) begin
               if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                  samp_nxt  = '0;
                  shift_nxt = {rxd_s, shift_q[DATA_BITS-1:1]};
                  bit_nxt   = bit_q + BIT_W'(1);
                  if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                     bit_nxt   = '0;
                     state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                  end
               end else begin
                  samp_nxt = samp_q + SAMP_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick_c) begin
               if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                  samp_nxt    = '0;
                  par_err_nxt = (PARITY == 2) ? ~(^shift_q ^ rxd_s) : (^shift_q ^ rxd_s);
`ifdef UART_RX_BREAK_DET_EN
                  par_bit_nxt = rxd_s;
`endif
                  state_nxt   = S_STOP;
               end else begin
                  samp_nxt = samp_q + SAMP_W'(1);
               end
            end
         end
         S_STOP: begin
            if (tick_c) begin
               if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                  samp_nxt = '0;
                  if (!rxd_s) frame_nxt = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                  if (bit_q == '0) begin
                     brk_nxt = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !rxd_s;
                  end
`endif
                  // Complete at mid-stop so a slightly fast sender is not lost
                  if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                     bit_nxt   = '0;
                     done_c    = 1'b1;
                     state_nxt = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                     if (brk_nxt) state_nxt = S_BREAK;
`endif
                  end else begin
                     bit_nxt = bit_q + BIT_W'(1);
                  end
               end else begin
                  samp_nxt = samp_q + SAMP_W'(1);
               end
            end
         end
`ifdef UART_RX_BREAK_DET_EN
         S_BREAK: begin
            // Leave only after the line has been high for one whole bit
            if (tick_c) begin
               if (!rxd_s) begin
                  samp_nxt = '0;
               end else if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                  samp_nxt  = '0;
                  state_nxt = S_IDLE;
               end else begin
                  samp_nxt = samp_q + SAMP_W'(1);
               end
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output holding register with overrun detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         rx_break      <= 1'b0;
`endif
      end else begin
         rx_overrun <= 1'b0;
         if (done_c) begin
            if (!rx_valid || rx_ready) begin
               rx_data       <= shift_q;
               rx_valid      <= 1'b1;
               rx_frame_err  <= frame_nxt;
               rx_parity_err <= par_err_nxt;
`ifdef UART_RX_BREAK_DET_EN
               rx_break      <= brk_nxt;
`endif
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifndef UART_RX_BREAK_DET_EN
   assign rx_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: an 8N1 instance and a 7E2 instance
// driven with directed and random characters, checked against a rule model.
module tb_uart_rx_core;

   localparam int unsigned CLK_FREQ = 7372800;     // 4 clocks per oversample tick
   localparam int BIT_CLKS = 64;                   // 4 * 16
   localparam int LAT_EXP  = 3 + (BIT_CLKS * 19) / 2;
   localparam int LAT_TOL  = 4;
`ifdef UART_RX_BREAK_DET_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd0, rxd1;
   logic       ready0, ready1;
   logic [7:0] rx_data0;
   logic [6:0] rx_data1;
   logic       rx_valid0, rx_valid1;
   logic       fe0, fe1, pe0, pe1, ovr0, ovr1, brk0, brk1;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int rise0  = 0;
   int ovr_cnt0 = 0;
   int ovr_cnt1 = 0;
   int start_cyc0 = 0;
   logic vprev0 = 1'b0;
   logic [11:0] obs0[$];
   logic [11:0] obs1[$];

   uart_rx_core #(.CLK_FREQ(CLK_FREQ)) u_dut0 (
      .clk(clk), .rst(rst), .uart_rxd(rxd0),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(ready0),
      .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_overrun(ovr0), .rx_break(brk0)
   );

   uart_rx_core #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                  .SYNC_STAGES(3)) u_dut1 (
      .clk(clk), .rst(rst), .uart_rxd(rxd1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(ready1),
      .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_overrun(ovr1), .rx_break(brk1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted character and overrun cycles
   always @(negedge clk) begin
      if (rx_valid0 && ready0) obs0.push_back({brk0, pe0, fe0, 1'b0, rx_data0});
      if (rx_valid1 && ready1) obs1.push_back({brk1, pe1, fe1, 2'b00, rx_data1});
      if (rx_valid0 && !vprev0) rise0 <= cyc;
      vprev0 <= rx_valid0;
      if (ovr0) ovr_cnt0 <= ovr_cnt0 + 1;
      if (ovr1) ovr_cnt1 <= ovr_cnt1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input int which, input logic v, input int clks);
      if (which == 0) rxd0 = v; else rxd1 = v;
      repeat (clks) @(posedge clk);
      #1;
   endtask

   function automatic logic parity_bit(input logic [8:0] d, input int pm, input bit flip);
      return ((pm == 2) ? ~(^d) : (^d)) ^ flip;
   endfunction

   // Expected {break, parity_err, frame_err, data} from the framing rules
   function automatic logic [11:0] model(input logic [8:0] d, input int nbits, input int pm,
                                         input bit flip, input bit stop0);
      logic [8:0] m;
      logic pbit, pe, brk;
      m    = d & ((9'(1) << nbits) - 9'(1));
      pbit = parity_bit(m, pm, flip);
      pe   = (pm == 0) ? 1'b0 : ((pm == 1) ? (^m ^ pbit) : ~(^m ^ pbit));
      brk  = BRK_EN && (m == 9'd0) && ((pm == 0) || !pbit) && stop0;
      return {brk, pe, stop0, m};
   endfunction

   task automatic send_char(input int which, input logic [8:0] d, input int nbits, input int pm,
                            input bit flip, input bit stop0, input int nstop);
      if (which == 0) start_cyc0 = cyc;
      drive(which, 1'b0, BIT_CLKS);
      for (int i = 0; i < nbits; i++) drive(which, d[i], BIT_CLKS);
      if (pm != 0) drive(which, parity_bit(d & ((9'(1) << nbits) - 9'(1)), pm, flip), BIT_CLKS);
      for (int s = 0; s < nstop; s++) drive(which, (s == 0) ? !stop0 : 1'b1, BIT_CLKS);
      drive(which, 1'b1, BIT_CLKS);
   endtask

   task automatic expect_char(input int which, input string tag, input logic [11:0] e);
      logic [11:0] o;
      int sz;
      sz = (which == 0) ? obs0.size() : obs1.size();
      chk({tag, " count"}, 32'(sz), 32'd1);
      if (sz > 0) begin
         if (which == 0) o = obs0.pop_front(); else o = obs1.pop_front();
         chk({tag, " data"},  32'(o[8:0]), 32'(e[8:0]));
         chk({tag, " frame"}, 32'(o[9]),   32'(e[9]));
         chk({tag, " parity"},32'(o[10]),  32'(e[10]));
         chk({tag, " break"}, 32'(o[11]),  32'(e[11]));
      end
   endtask

   task automatic check_latency(input string tag);
      int lat;
      lat = rise0 - start_cyc0;
      chk(tag, (lat >= LAT_EXP - LAT_TOL && lat <= LAT_EXP + LAT_TOL) ? 32'(LAT_EXP) : 32'(lat),
          32'(LAT_EXP));
   endtask

   initial begin
      logic [8:0] d;
      bit s0, fl;
      int ovr_base;

      rst = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("reset valid0",  32'(rx_valid0), 32'd0);
      chk("reset data0",   32'(rx_data0),  32'd0);
      chk("reset flags0",  32'({fe0, pe0, ovr0, brk0}), 32'd0);
      chk("reset valid1",  32'(rx_valid1), 32'd0);
      chk("reset data1",   32'(rx_data1),  32'd0);
      rst = 1'b0;
      drive(0, 1'b1, 2 * BIT_CLKS);

      send_char(0, 9'hA5, 8, 0, 1'b0, 1'b0, 1);
      expect_char(0, "a5", model(9'hA5, 8, 0, 1'b0, 1'b0));
      check_latency("a5 latency");

      // Short low glitch must not produce a character
      drive(0, 1'b0, (BIT_CLKS * 3) / 10);
      drive(0, 1'b1, 2 * BIT_CLKS);
      chk("glitch no char", 32'(obs0.size()), 32'd0);
      chk("glitch valid",   32'(rx_valid0),   32'd0);
      send_char(0, 9'h3C, 8, 0, 1'b0, 1'b0, 1);
      expect_char(0, "3c", model(9'h3C, 8, 0, 1'b0, 1'b0));
      check_latency("3c latency");

      send_char(0, 9'h55, 8, 0, 1'b0, 1'b1, 1);
      expect_char(0, "55 stop0", model(9'h55, 8, 0, 1'b0, 1'b1));
      send_char(0, 9'hFF, 8, 0, 1'b0, 1'b0, 1);
      expect_char(0, "ff", model(9'hFF, 8, 0, 1'b0, 1'b0));

      for (int i = 0; i < 8; i++) begin
         d  = 9'($urandom_range(0, 255));
         s0 = ($urandom_range(0, 3) == 0);
         if (s0 && d == 9'd0) d = 9'd1;
         send_char(0, d, 8, 0, 1'b0, s0, 1);
         expect_char(0, "rand 8n1", model(d, 8, 0, 1'b0, s0));
      end

      send_char(1, 9'h41, 7, 1, 1'b0, 1'b0, 2);
      expect_char(1, "41 par ok", model(9'h41, 7, 1, 1'b0, 1'b0));
      send_char(1, 9'h41, 7, 1, 1'b1, 1'b0, 2);
      expect_char(1, "41 par bad", model(9'h41, 7, 1, 1'b1, 1'b0));
      for (int i = 0; i < 6; i++) begin
         d  = 9'($urandom_range(0, 127));
         fl = ($urandom_range(0, 1) == 1);
         s0 = ($urandom_range(0, 3) == 0);
         if (s0 && d == 9'd0) d = 9'd1;
         send_char(1, d, 7, 1, fl, s0, 2);
         expect_char(1, "rand 7e2", model(d, 7, 1, fl, s0));
      end

      // Held character plus a dropped one
      ready0 = 1'b0;
      ovr_base = ovr_cnt0;
      send_char(0, 9'h11, 8, 0, 1'b0, 1'b0, 1);
      send_char(0, 9'h22, 8, 0, 1'b0, 1'b0, 1);
      chk("overrun hold valid", 32'(rx_valid0), 32'd1);
      chk("overrun hold data",  32'(rx_data0),  32'h11);
      chk("overrun pulses",     32'(ovr_cnt0 - ovr_base), 32'd1);
      ready0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("overrun drained valid", 32'(rx_valid0), 32'd0);
      expect_char(0, "overrun 11", model(9'h11, 8, 0, 1'b0, 1'b0));
      drive(0, 1'b1, 3 * BIT_CLKS);
      chk("overrun 22 absent", 32'(obs0.size()), 32'd0);

      // Reset in the middle of a character aborts it
      drive(0, 1'b0, BIT_CLKS);
      drive(0, 1'b1, BIT_CLKS);
      drive(0, 1'b0, BIT_CLKS / 2);
      rst = 1'b1; rxd0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 1'b1, 12 * BIT_CLKS);
      chk("midreset no char", 32'(obs0.size()), 32'd0);
      chk("midreset valid",   32'(rx_valid0),   32'd0);
      chk("midreset flags",   32'({fe0, pe0, brk0}), 32'd0);

      // Long low line: one all-zero character with frame error
      drive(0, 1'b0, 20 * BIT_CLKS);
      drive(0, 1'b1, 2 * BIT_CLKS);
      expect_char(0, "break", model(9'h00, 8, 0, 1'b0, 1'b1));
      send_char(0, 9'h7E, 8, 0, 1'b0, 1'b0, 1);
      expect_char(0, "7e after break", model(9'h7E, 8, 0, 1'b0, 1'b0));

      chk("dut1 no overrun", 32'(ovr_cnt1), 32'd0);
      chk("dut1 no extra",   32'(obs1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
